// File: rtl/ex_mem_stage_buf.sv
// ex_mem_stage_buf: elastic pipeline stage register with valid/ready handshake
// and a two-entry (main + skid) buffer. It is used at the EX/MEM boundary and at
// any other stage boundary.
//
// - out_valid, out_ctrl and out_data come straight from registers.
// - in_ready is decoded from the registered state only. No combinational path
//   runs from out_ready to in_ready.
// - flush kills every held entry. It clears the control payload, so RegWrite,
//   MemRead and MemWrite cannot leak into the next stage.
//
// Optional feature: define EX_MEM_STAGE_STALL_CNT_EN to build a saturating
// counter of stalled output cycles on stall_cnt. When the macro is not defined,
// stall_cnt is tied to zero and the port is kept.

module ex_mem_stage_buf #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Bit 0 is the main-entry valid bit and bit 1 is the skid-entry valid bit.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [CTRL_W-1:0] main_ctrl_nxt_s;
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] main_data_nxt_s;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [CTRL_W-1:0] skid_ctrl_nxt_s;
    logic [DATA_W-1:0] skid_data_r;
    logic [DATA_W-1:0] skid_data_nxt_s;
    logic              accept_s;
    logic              drain_s;

    assign in_ready  = (state_r != ST_SKID);
    assign out_valid = (state_r != ST_EMPTY);
    assign out_ctrl  = main_ctrl_r;
    assign out_data  = main_data_r;

    assign accept_s  = in_valid & in_ready;
    assign drain_s   = out_valid & out_ready;

    // Next-state and payload steering. flush overrides every handshake event.
    always_comb begin
        state_nxt_s     = state_r;
        main_ctrl_nxt_s = main_ctrl_r;
        main_data_nxt_s = main_data_r;
        skid_ctrl_nxt_s = skid_ctrl_r;
        skid_data_nxt_s = skid_data_r;
        if (flush) begin
            // Kill both entries. Any input offered in this cycle is dropped.
            state_nxt_s     = ST_EMPTY;
            main_ctrl_nxt_s = {CTRL_W{1'b0}};
            skid_ctrl_nxt_s = {CTRL_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s     = ST_FULL;
                        main_ctrl_nxt_s = in_ctrl;
                        main_data_nxt_s = in_data;
                    end else begin
                        state_nxt_s     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain_s && accept_s) begin
                        state_nxt_s     = ST_FULL;
                        main_ctrl_nxt_s = in_ctrl;
                        main_data_nxt_s = in_data;
                    end else if (drain_s) begin
                        // A bubble follows, so its control bits must read zero.
                        // The data bits keep their last value.
                        state_nxt_s     = ST_EMPTY;
                        main_ctrl_nxt_s = {CTRL_W{1'b0}};
                    end else if (accept_s) begin
                        state_nxt_s     = ST_SKID;
                        skid_ctrl_nxt_s = in_ctrl;
                        skid_data_nxt_s = in_data;
                    end else begin
                        state_nxt_s     = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (drain_s) begin
                        state_nxt_s     = ST_FULL;
                        main_ctrl_nxt_s = skid_ctrl_r;
                        main_data_nxt_s = skid_data_r;
                        skid_ctrl_nxt_s = {CTRL_W{1'b0}};
                    end else begin
                        state_nxt_s     = ST_SKID;
                    end
                end
                default: begin
                    // An unreachable encoding recovers to a clean, empty stage.
                    state_nxt_s     = ST_EMPTY;
                    main_ctrl_nxt_s = {CTRL_W{1'b0}};
                    skid_ctrl_nxt_s = {CTRL_W{1'b0}};
                end
            endcase
        end
    end

    // State and payload registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            main_ctrl_r <= main_ctrl_nxt_s;
            main_data_r <= main_data_nxt_s;
            skid_ctrl_r <= skid_ctrl_nxt_s;
            skid_data_r <= skid_data_nxt_s;
        end
    end

`ifdef EX_MEM_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Count cycles where a valid output is blocked downstream. The count
    // saturates, and only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid && !out_ready && !flush &&
                     (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Directed testbench for ex_mem_stage_buf. It drives and samples inputs on the
// falling edge, so outputs are read halfway between active edges.
module tb_ex_mem_stage_buf;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

`ifdef EX_MEM_STAGE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int tests_run;
    int tests_failed;

    ex_mem_stage_buf #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (out_ctrl !== 16'h0000) begin tests_failed++; $display("FAIL reset_out_ctrl: got %h expected 0000", out_ctrl); end
        tests_run++;
        if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++;
        if (stall_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_ctrl   = 16'h0011;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'(i);
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) || out_ctrl !== 16'h0011) begin
                tests_failed++;
                $display("FAIL stream_out[%0d]: got v=%b d=%h c=%h expected v=1 d=%h c=0011", i, out_valid, out_data, out_ctrl, 32'(i));
            end
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0000) begin
            tests_failed++;
            $display("FAIL stream_drained: got v=%b c=%h expected v=0 c=0000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        in_valid  = 1'b1;
        in_ctrl   = 16'h0022;
        in_data   = 32'hA;
        out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_load_a: got v=%b d=%h r=%b expected v=1 d=a r=1", out_valid, out_data, in_ready);
        end
        in_data = 32'hB;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== 32'hA) begin
            tests_failed++;
            $display("FAIL bp_skid: got r=%b d=%h expected r=0 d=a", in_ready, out_data);
        end
        in_data = 32'hC;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
            tests_failed++;
            $display("FAIL bp_hold: got r=%b v=%b d=%h expected r=0 v=1 d=a", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_out_b: got v=%b d=%h r=%b expected v=1 d=b r=1", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hC || out_ctrl !== 16'h0022) begin
            tests_failed++;
            $display("FAIL bp_out_c: got v=%b d=%h c=%h expected v=1 d=c c=0022", out_valid, out_data, out_ctrl);
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_flush_skid();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h00FF;
        in_data   = 32'hE;
        @(negedge clk);
        in_data = 32'hF;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_pre_skid: got r=%b expected 0", in_ready); end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hD;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0000 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_next: got v=%b c=%h r=%b expected v=0 c=0000 r=1", out_valid, out_ctrl, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_no_d[%0d]: got v=%b d=%h expected v=0", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_bubble();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_ctrl   = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0 || out_ctrl !== 16'h0000) begin
                tests_failed++;
                $display("FAIL bubble[%0d]: got v=%b c=%h expected v=0 c=0000", i, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        in_ctrl   = 16'h0033;
        in_data   = 32'h55;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h55) begin
            tests_failed++;
            $display("FAIL arst_load: got v=%b d=%h expected v=1 d=55", out_valid, out_data);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0000 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_clear: got v=%b c=%h d=%h r=%b expected v=0 c=0000 d=0 r=1", out_valid, out_ctrl, out_data, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stall_cnt();
        logic [CNT_W-1:0] exp5;
        logic [CNT_W-1:0] exp15;
        exp5  = CNT_EN ? 4'd5  : 4'd0;
        exp15 = CNT_EN ? 4'd15 : 4'd0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h0044;
        in_data   = 32'h77;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (stall_cnt !== exp5) begin tests_failed++; $display("FAIL stall_count5: got %0d expected %0d", stall_cnt, exp5); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests_run++;
        if (stall_cnt !== exp5) begin tests_failed++; $display("FAIL stall_after_flush: got %0d expected %0d", stall_cnt, exp5); end
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (stall_cnt !== exp15) begin tests_failed++; $display("FAIL stall_saturate: got %0d expected %0d", stall_cnt, exp15); end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (stall_cnt !== 4'd0) begin tests_failed++; $display("FAIL stall_reset: got %0d expected 0", stall_cnt); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_ctrl      = 16'h0000;
        in_data      = 32'h0;
        out_ready    = 1'b0;

        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_skid();
        test_bubble();
        test_async_reset();
        test_stall_cnt();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_buf.md
Name: ex_mem_stage_buf

Overview:
- Parametrised, elastic pipeline stage register for the EX/MEM boundary and any other stage boundary.
- Replaces fixed always-load stage registers with a valid/ready handshake and a two-entry skid buffer.
- Adds a flush that inserts a bubble by clearing control bits such as RegWrite, MemRead and MemWrite.
- Outputs are fully registered, and no combinational path runs from out_ready to in_ready.

Parameters:
- DATA_W, 96: width of the data payload (e.g. ALUout, store data, branch target).
- CTRL_W, 16: width of the control payload; forced to zero whenever the stage holds no valid entry.
- CNT_W, 16: width of the stall counter (optional feature only).

Ports:
- clk  input  1  clock; everything is updated on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  the upstream stage presents an entry.
- in_ready  output  1  this stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  control payload.
- in_data  input  DATA_W  data payload.
- out_valid  output  1  the output entry is valid.
- out_ready  input  1  the downstream stage consumes the entry this cycle.
- out_ctrl  output  CTRL_W  registered control payload; zero when out_valid=0.
- out_data  output  DATA_W  registered data payload.
- stall_cnt  output  CNT_W  count of stalled cycles (see Optional Feature).

Behaviour:
- Reset (async): out_valid=0, out_ctrl=0, out_data=0, skid entry invalid and zeroed, in_ready=1, stall_cnt=0.
- Definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- States are encoded by the main/skid valid bits: EMPTY, FULL, SKID.
- EMPTY:
  - accept -> FULL, main <= input.
- FULL:
  - drain & accept -> FULL, main <= input.
  - drain & !accept -> EMPTY.
  - !drain & accept -> SKID, skid <= input.
  - otherwise hold FULL.
- SKID:
  - drain -> FULL, main <= skid, skid invalidated.
  - otherwise hold SKID.
  - Input is never accepted in SKID.
- in_ready = (state != SKID). It is a function of registered state only.
- Latency: 1 cycle from accept to out_valid when EMPTY. Sustained throughput is 1 entry/cycle while out_ready=1.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush.
- Payload in the EMPTY state: out_ctrl=0 and out_data holds its last value. The bench must not check out_data while out_valid=0.
- Flush:
  - Has priority over every other event, including a simultaneous accept and drain.
  - Next state is EMPTY; out_ctrl=0 and the skid entry is invalidated.
  - An input offered in the flush cycle is discarded, even though in_ready may read 1.
  - in_ready=1 in the next cycle.
- Reset asserted mid-operation gives the same result as the reset values above, immediately and with no clock edge needed.
- out_valid=0 while out_ready=1 is legal and causes no state change.

Optional Feature:
- Macro: EX_MEM_STAGE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each cycle with out_valid & !out_ready & !flush.
  - It saturates at all-ones and does not wrap.
  - It clears only on reset; flush does not clear it.
- Undefined:
  - stall_cnt is tied to 0 and no counter logic is synthesised.
  - The port is still present, so instantiations do not change.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 4 cycles with in_data=1,2,3,4 and in_ctrl=16'h0011. Required:
  - out_data=1,2,3,4 on consecutive cycles, starting 1 cycle after the first accept.
  - in_ready stays 1 throughout.
- Back-pressure: load A=32'hA, then set out_ready=0 and offer B=32'hB. Required:
  - The stage enters SKID and in_ready=0 on the next cycle.
  - Offering C=32'hC while in SKID is not accepted.
  - On out_ready=1 the outputs are A then B, in_ready returns to 1, and C is accepted after that.
- Flush in SKID with a simultaneous in_valid=1 (D=32'hD). Required:
  - Next cycle: out_valid=0, out_ctrl=0, in_ready=1.
  - D never appears at the output.
- Bubble: in_valid=0 for 3 cycles with out_ready=1. Required: out_valid=0 and out_ctrl=0 on every cycle, so RegWrite/MemWrite are never asserted.
- Async reset in FULL: assert reset between clock edges. Required:
  - out_valid, out_ctrl and out_data go to 0 before the next edge.
  - in_ready=1.
- Macro defined, CNT_W=4: hold out_ready=0 with a valid entry for 20 cycles. Required:
  - stall_cnt saturates at 15.
  - It is unchanged by a flush and clears to 0 on reset.
  - With the macro undefined it reads 0 throughout.
